// File: rtl/stage_1_pkg.sv
// Shared constants and types for the instruction fetch stage.
//   NOP_INST_DEF : word shown to decode when the buffer is empty (addi x0,x0,0)
//   PC_INC       : sequential fetch step
//   FIFO_W       : width of one buffered entry, {pc, inst}
//   fetch_state_t: RUN = normal fetch, SQUASH = draining a wrong-path request
package stage_1_pkg;

    localparam logic [31:0] NOP_INST_DEF = 32'h00000013;
    localparam logic [31:0] PC_INC       = 32'd4;
    localparam int unsigned FIFO_W       = 64;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_SQUASH = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/stage_1_inst_fifo.sv
// Instruction buffer between the memory port and decode.
// Ports:
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_push         : write i_push_data at the tail
//   i_push_data    : {pc, inst}
//   i_pop          : drop the head entry (caller only pops when non-empty)
//   i_flush        : empty the buffer; wins over push and pop
//   o_head         : head entry, valid when o_count != 0
//   o_count        : number of stored entries (0..DEPTH)
module inst_fifo
    import stage_1_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  logic [FIFO_W-1:0]          i_push_data,
    input  logic                       i_pop,
    input  logic                       i_flush,
    output logic [FIFO_W-1:0]          o_head,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [FIFO_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            if (i_push && !i_pop)
                r_count <= r_count + CW'(1);
            else if (!i_push && i_pop)
                r_count <= r_count - CW'(1);
        end
    end

    // Storage needs no reset: entries are only read while counted as valid.
    always_ff @(posedge i_clk) begin
        if (i_push && !i_flush)
            r_mem[r_wr_ptr] <= i_push_data;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/stage_1.sv
// Instruction fetch stage: drives a single-outstanding req/ack memory port,
// buffers returned words for decode, and squashes wrong-path fetches on a
// taken-branch redirect from decode.
// Ports:
//   i_clk, i_rst           : clock, synchronous active-high reset
//   i_b_taken, i_b_pc      : redirect request and target (bits [1:0] ignored)
//   i_stall                : decode not ready, head entry held
//   mem_req, mem_addr      : fetch request and word address
//   i_mem_ack, i_mem_data  : memory response for the current request
//   inst, pc, valid        : head instruction and its PC for decode
module stage_1
    import stage_1_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h00000000,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INST   = NOP_INST_DEF
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_b_taken,
    input  logic [31:0] i_b_pc,
    input  logic        i_stall,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_data,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic        valid
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;
    logic [31:0]  r_fetch_pc;
    logic [31:0]  r_req_addr;
    logic         r_outstanding;
    logic         r_issue_en;

    logic          w_ack;
    logic          w_push;
    logic          w_pop;
    logic          w_valid;
    logic [63:0]   w_head;
    logic [CW-1:0] w_count;
    logic          w_unused_bpc;

    assign w_unused_bpc = ^i_b_pc[1:0];

    // A slot is reserved at issue: count < depth with nothing in flight means
    // the returning word always fits. An in-flight request holds req/addr.
    assign mem_req  = r_outstanding
                    | (r_issue_en && (r_state == ST_RUN) && (w_count < DEPTH_C));
    assign mem_addr = r_outstanding ? r_req_addr : r_fetch_pc;

    assign w_ack   = mem_req & i_mem_ack;
    assign w_valid = (w_count != '0);
    assign w_push  = w_ack && (r_state == ST_RUN) && !i_b_taken;
    assign w_pop   = w_valid && !i_stall && !i_b_taken;

    always_comb begin
        w_state_nxt = r_state;
        if (i_b_taken)
            // A request still in flight after this edge returns wrong-path data.
            w_state_nxt = (mem_req && !w_ack) ? ST_SQUASH : ST_RUN;
        else if ((r_state == ST_SQUASH) && w_ack)
            w_state_nxt = ST_RUN;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= ST_RUN;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fetch_pc    <= RESET_PC;
            r_req_addr    <= RESET_PC;
            r_outstanding <= 1'b0;
            r_issue_en    <= 1'b0;
        end else begin
            r_issue_en <= 1'b1;
            if (i_b_taken)
                r_fetch_pc <= {i_b_pc[31:2], 2'b00};
            else if (w_push)
                r_fetch_pc <= r_fetch_pc + PC_INC;
            r_outstanding <= mem_req && !w_ack;
            if (mem_req && !w_ack)
                r_req_addr <= mem_addr;
        end
    end

    inst_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (w_push),
        .i_push_data ({mem_addr, i_mem_data}),
        .i_pop       (w_pop),
        .i_flush     (i_b_taken),
        .o_head      (w_head),
        .o_count     (w_count)
    );

    assign valid = w_valid;
    assign inst  = w_valid ? w_head[31:0]  : NOP_INST;
    assign pc    = w_valid ? w_head[63:32] : 32'h0;

endmodule

// File: tb/tb_stage_1.sv
module tb_stage_1;
    import stage_1_pkg::*;

    localparam logic [31:0] T_RESET_PC = 32'hFFFFFFF8;
    localparam int          DEPTH      = 2;
    localparam int          N_CYC      = 3000;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_b_taken;
    logic [31:0] i_b_pc;
    logic        i_stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        i_mem_ack;
    logic [31:0] i_mem_data;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        valid;

    always #5 clk = ~clk;

    stage_1 #(
        .RESET_PC   (T_RESET_PC),
        .FIFO_DEPTH (DEPTH),
        .NOP_INST   (32'h00000013)
    ) dut (
        .i_clk      (clk),
        .i_rst      (i_rst),
        .i_b_taken  (i_b_taken),
        .i_b_pc     (i_b_pc),
        .i_stall    (i_stall),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .i_mem_ack  (i_mem_ack),
        .i_mem_data (i_mem_data),
        .inst       (inst),
        .pc         (pc),
        .valid      (valid)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h13579BDF;
    endfunction

    // Transaction-level reference: the buffer is a queue of {pc,inst},
    // plus the next fetch address and the in-flight request.
    logic [63:0] m_q[$];
    logic [31:0] m_fetch;
    logic [31:0] m_out_addr;
    bit          m_out;
    bit          m_squash;
    bit          m_started;

    task automatic model_reset();
        m_q.delete();
        m_fetch    = T_RESET_PC;
        m_out_addr = T_RESET_PC;
        m_out      = 1'b0;
        m_squash   = 1'b0;
        m_started  = 1'b0;
    endtask

    bit          mem_active;
    int          mem_wait;
    int          lat_max;
    logic        exp_req;
    logic [31:0] exp_addr;
    bit          ack_c;

    initial begin
        i_rst      = 1'b1;
        i_b_taken  = 1'b0;
        i_b_pc     = '0;
        i_stall    = 1'b0;
        i_mem_ack  = 1'b0;
        i_mem_data = '0;
        mem_active = 1'b0;
        mem_wait   = 0;
        repeat (2) @(posedge clk);
        model_reset();

        for (int cyc = 0; cyc < N_CYC; cyc++) begin
            @(negedge clk);
            exp_req  = m_out || (m_started && !m_squash && (m_q.size() < DEPTH));
            exp_addr = m_out ? m_out_addr : m_fetch;

            chk_val("valid",    64'(valid),    64'(m_q.size() != 0));
            chk_val("pc",       64'(pc),       (m_q.size() != 0) ? 64'(m_q[0][63:32]) : 64'h0);
            chk_val("inst",     64'(inst),     (m_q.size() != 0) ? 64'(m_q[0][31:0])  : 64'h13);
            chk_val("mem_req",  64'(mem_req),  64'(exp_req));
            chk_val("mem_addr", 64'(mem_addr), 64'(exp_addr));

            // Stimulus: clean zero-wait stream, then heavy stall, then random mix.
            if (cyc < 60) begin
                lat_max = 0; i_stall = 1'b0; i_b_taken = 1'b0; i_rst = 1'b0;
            end else if (cyc < 160) begin
                lat_max   = 0;
                i_stall   = ($urandom_range(0, 3) != 0);
                i_b_taken = 1'b0;
                i_rst     = (cyc == 120);
            end else begin
                lat_max   = 3;
                i_stall   = ($urandom_range(0, 2) == 0);
                i_b_taken = ($urandom_range(0, 9) == 0);
                i_rst     = ($urandom_range(0, 249) == 0);
            end
            i_b_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 | 32'($urandom_range(0, 15)))
                                                 : $urandom();

            i_mem_ack  = 1'b0;
            i_mem_data = $urandom();
            if (mem_req === 1'b1) begin
                if (!mem_active) begin
                    mem_active = 1'b1;
                    mem_wait   = $urandom_range(0, lat_max);
                end
                if (mem_wait == 0) begin
                    i_mem_ack  = 1'b1;
                    i_mem_data = mem_word(mem_addr);
                    mem_active = 1'b0;
                end else begin
                    mem_wait--;
                end
            end

            ack_c = exp_req && i_mem_ack;
            if (i_rst) begin
                model_reset();
                mem_active = 1'b0;
            end else begin
                if (i_b_taken) begin
                    m_q.delete();
                    m_fetch  = {i_b_pc[31:2], 2'b00};
                    m_squash = exp_req && !ack_c;
                end else begin
                    if ((m_q.size() != 0) && !i_stall)
                        void'(m_q.pop_front());
                    if (ack_c && !m_squash) begin
                        m_q.push_back({exp_addr, mem_word(exp_addr)});
                        m_fetch = m_fetch + 32'd4;
                    end
                    if (ack_c) m_squash = 1'b0;
                end
                m_out      = exp_req && !ack_c;
                m_out_addr = exp_addr;
                m_started  = 1'b1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/stage_1.md
Name: stage_1

Overview:
Instruction fetch stage; feeds decode with the instruction word and its PC, and takes branch redirects back from decode.
- Holds the fetch PC and drives a single-outstanding req/ack instruction-memory port.
- Buffers returned words in a small FIFO so decode stalls do not block memory.
- Squashes wrong-path fetches when decode signals a taken branch.

Parameters:
RESET_PC, 32'h00000000, fetch address loaded on reset.
FIFO_DEPTH, 2, instruction buffer entries (power of two, >= 2).
NOP_INST, 32'h00000013, word presented on inst when no valid entry (addi x0,x0,0).

Ports:
i_clk  in  1  clock, all state updates on rising edge.
i_rst  in  1  reset, synchronous, active-high.
i_b_taken  in  1  decode redirect request, sampled each cycle.
i_b_pc  in  32  redirect target; bits [1:0] ignored (forced 00).
i_stall  in  1  decode not ready; head entry held while high.
mem_req  out  1  instruction fetch request.
mem_addr  out  32  word address of request.
i_mem_ack  in  1  memory returns i_mem_data for current request this cycle.
i_mem_data  in  32  instruction word, valid with i_mem_ack.
inst  out  32  instruction to decode (FIFO head, else NOP_INST).
pc  out  32  PC of inst (FIFO head, else 0).
valid  out  1  inst/pc hold a real instruction.

Behaviour:
- Reset, i_rst high at an edge:
  - fetch_pc=RESET_PC, state=RUN, FIFO empty.
  - mem_req=0, mem_addr=RESET_PC, valid=0, inst=NOP_INST, pc=0.
  - Reset overrides everything, including an in-flight request; an ack in the reset cycle is dropped.
- States: RUN, SQUASH.
- RUN issue rule: mem_req asserted when count + outstanding < FIFO_DEPTH; mem_addr = fetch_pc.
  - First req is asserted in the cycle after reset deasserts.
- Handshake rules:
  - Once mem_req is high, mem_req and mem_addr stay constant until the i_mem_ack cycle.
  - At most one outstanding request.
  - mem_req drops the cycle after ack, unless the issue rule allows a back-to-back request at fetch_pc+4 (which is allowed).
- Ack in RUN, no redirect: push {mem_addr, i_mem_data}; fetch_pc += 4 (32-bit wrap, FFFFFFFC -> 0).
  - Latency: ack in cycle N -> valid/inst/pc visible from cycle N+1.
- Output side:
  - valid = FIFO non-empty; inst/pc combinationally from head.
  - Pop when valid && !i_stall.
  - Push and pop in the same cycle are both allowed.
  - Occupancy is bounded by reserving a slot at issue, so a push never overflows.
- Redirect, i_b_taken=1 at an edge:
  - FIFO cleared; that cycle's pop is irrelevant.
  - fetch_pc = {i_b_pc[31:2],2'b00}.
  - No request outstanding, or ack in the same cycle: ack data discarded, stay RUN; the next request uses the new PC the following cycle.
  - Request outstanding without ack: go to SQUASH.
- SQUASH:
  - mem_req stays high at the old address; valid=0; nothing pushed.
  - On i_mem_ack: data discarded, go to RUN; the request to the redirect target is issued next cycle.
  - Further i_b_taken in SQUASH updates fetch_pc only (last redirect wins).
- Priority: reset > redirect > ack push > pop.
- i_stall has no effect on the memory side except through FIFO occupancy.

Decomposition:
- Shared constants package/header: NOP_INST value, state encodings (RUN=1'b0, SQUASH=1'b1), PC increment (4).
- One sub-module, inst_fifo: parameterised FIFO_DEPTH x 64-bit {pc,inst}.
  - Ports: push, pop, flush, head data, count.
  - Pointer wrap via log2(FIFO_DEPTH) bits; count is log2+1 bits.
- Top level holds fetch_pc, the state register and the outstanding flag.

Test Plan:
- Reset then zero-wait memory (ack same cycle as req), i_stall=0 -> mem_addr 0,4,8,... in consecutive cycles; valid from cycle 2 with pc=0, then 4, 8 each cycle; inst matches memory.
- i_stall=1 held 5 cycles after first valid -> after 2 acks mem_req stays 0; inst/pc frozen at pc=0; release -> pc=0,4,8 delivered in order, no duplicate or drop.
- Memory 3-cycle latency, mem_addr=8 outstanding, i_b_taken=1 with i_b_pc=32'h103 -> state SQUASH, mem_req held at 8 until ack; ack data discarded, never valid; next req addr 32'h100; first valid pc=32'h100.
- i_b_taken coincident with ack of addr 4, with FIFO holding pc=0 -> FIFO emptied, valid=0 next cycle; next req at i_b_pc; no entry with pc 0 or 4 appears.
- RESET_PC=32'hFFFFFFF8, zero-wait memory -> delivered pc sequence FFFFFFF8, FFFFFFFC, 00000000.
- i_rst asserted while request outstanding and FIFO full -> next cycle mem_req=0, valid=0, inst=00000013, pc=0; fetch restarts at RESET_PC.
